// File: rtl/ps2_host_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : ps2_host_tx_if
// Brief    : CPU-side write/status bundle for the PS/2 host transmitter.
// Revision : 1.0
// ============================================================================
interface ps2_host_tx_if;
    logic        wr;
    logic [7:0]  din;
    logic        busy;
    logic        done;
    logic [31:0] status;

    modport master (output wr, din, input busy, done, status);
    modport slave  (input wr, din, output busy, done, status);
endinterface
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_host_tx
// Brief    : PS/2 host-to-device command transmitter driving open-drain enables.
// Revision : 1.0
// ============================================================================
module ps2_host_tx #(
    parameter int INHIBIT_CYC = 5000,
    parameter int REQ_CYC     = 16,
    parameter int TIMEOUT_CYC = 750000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ps2_c,
    input  logic         ps2_d,
    ps2_host_tx_if.slave cpu,
    output logic         ps2_c_oe,
    output logic         ps2_d_oe
);

    localparam int c_PH_MAX = (INHIBIT_CYC > REQ_CYC) ? INHIBIT_CYC : REQ_CYC;
    localparam int c_PH_W   = (c_PH_MAX > 1) ? $clog2(c_PH_MAX) : 1;
    localparam int c_TO_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [c_PH_W-1:0] c_INH_LAST = c_PH_W'(INHIBIT_CYC - 1);
    localparam logic [c_PH_W-1:0] c_REQ_LAST = c_PH_W'(REQ_CYC - 1);
    localparam logic [c_TO_W-1:0] c_TO_LAST  = c_TO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_INHIBIT  = 3'd1,
        S_REQ      = 3'd2,
        S_SHIFT    = 3'd3,
        S_ACK      = 3'd4,
        S_WAITIDLE = 3'd5
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [c_PH_W-1:0]   r_phase_cnt, w_phase_cnt_nxt;
    logic [c_TO_W-1:0]   r_to_cnt, w_to_cnt_nxt;
    logic [3:0]          r_bit_cnt, w_bit_cnt_nxt;
    logic [7:0]          r_data, w_data_nxt;
    logic                r_par, w_par_nxt;
    logic                r_c_oe, w_c_oe_nxt;
    logic                r_d_oe, w_d_oe_nxt;
    logic                r_done, w_done_nxt;
    logic                r_err_noack, w_err_noack_nxt;
    logic                r_err_timeout, w_err_timeout_nxt;

    // [0] metastable stage, [1] synced level, [2] previous synced level
    logic [2:0]          r_c_sync;
    logic [1:0]          r_d_sync;
    logic                w_c_fall;
    logic                w_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_c_sync <= '1;
            r_d_sync <= '1;
        end else begin
            r_c_sync <= {r_c_sync[1:0], ps2_c};
            r_d_sync <= {r_d_sync[0], ps2_d};
        end
    end

    assign w_c_fall = (r_c_sync[2:1] == 2'b10);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_phase_cnt   <= '0;
            r_to_cnt      <= '0;
            r_bit_cnt     <= '0;
            r_data        <= '0;
            r_par         <= 1'b0;
            r_c_oe        <= 1'b0;
            r_d_oe        <= 1'b0;
            r_done        <= 1'b0;
            r_err_noack   <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_phase_cnt   <= w_phase_cnt_nxt;
            r_to_cnt      <= w_to_cnt_nxt;
            r_bit_cnt     <= w_bit_cnt_nxt;
            r_data        <= w_data_nxt;
            r_par         <= w_par_nxt;
            r_c_oe        <= w_c_oe_nxt;
            r_d_oe        <= w_d_oe_nxt;
            r_done        <= w_done_nxt;
            r_err_noack   <= w_err_noack_nxt;
            r_err_timeout <= w_err_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_phase_cnt_nxt   = r_phase_cnt;
        w_to_cnt_nxt      = r_to_cnt;
        w_bit_cnt_nxt     = r_bit_cnt;
        w_data_nxt        = r_data;
        w_par_nxt         = r_par;
        w_d_oe_nxt        = r_d_oe;
        w_done_nxt        = 1'b0;
        w_err_noack_nxt   = r_err_noack;
        w_err_timeout_nxt = r_err_timeout;
        w_c_oe_nxt        = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_d_oe_nxt = 1'b0;
                if (cpu.wr) begin
                    w_data_nxt        = cpu.din;
                    w_par_nxt         = ~^cpu.din;
                    w_err_noack_nxt   = 1'b0;
                    w_err_timeout_nxt = 1'b0;
                    w_phase_cnt_nxt   = '0;
                    w_state_nxt       = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                w_d_oe_nxt = 1'b0;
                if (r_phase_cnt == c_INH_LAST) begin
                    w_phase_cnt_nxt = '0;
                    w_d_oe_nxt      = 1'b1;
                    w_state_nxt     = S_REQ;
                end else begin
                    w_phase_cnt_nxt = r_phase_cnt + 1'b1;
                end
            end
            S_REQ: begin
                // Start bit stays driven into SHIFT until the first device edge
                w_d_oe_nxt    = 1'b1;
                w_bit_cnt_nxt = '0;
                w_to_cnt_nxt  = '0;
                if (r_phase_cnt == c_REQ_LAST) begin
                    w_phase_cnt_nxt = '0;
                    w_state_nxt     = S_SHIFT;
                end else begin
                    w_phase_cnt_nxt = r_phase_cnt + 1'b1;
                end
            end
            S_SHIFT: begin
                if (r_to_cnt == c_TO_LAST) begin
                    w_err_timeout_nxt = 1'b1;
                    w_state_nxt       = S_IDLE;
                end else begin
                    w_to_cnt_nxt = r_to_cnt + 1'b1;
                    if (w_c_fall) begin
                        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                        if (r_bit_cnt < 4'd8) begin
                            w_d_oe_nxt = ~r_data[r_bit_cnt[2:0]];
                        end else if (r_bit_cnt == 4'd8) begin
                            w_d_oe_nxt = ~r_par;
                        end else begin
                            w_d_oe_nxt  = 1'b0;
                            w_state_nxt = S_ACK;
                        end
                    end
                end
            end
            S_ACK: begin
                if (r_to_cnt == c_TO_LAST) begin
                    w_err_timeout_nxt = 1'b1;
                    w_state_nxt       = S_IDLE;
                end else begin
                    w_to_cnt_nxt = r_to_cnt + 1'b1;
                    if (w_c_fall) begin
                        if (!r_d_sync[1]) begin
                            w_state_nxt = S_WAITIDLE;
                        end else begin
                            w_err_noack_nxt = 1'b1;
                            w_state_nxt     = S_IDLE;
                        end
                    end
                end
            end
            S_WAITIDLE: begin
                w_d_oe_nxt = 1'b0;
                if (r_c_sync[1] && r_d_sync[1]) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_d_oe_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_state_nxt == S_IDLE) begin
            w_d_oe_nxt = 1'b0;
        end
        w_c_oe_nxt = (w_state_nxt == S_INHIBIT) || (w_state_nxt == S_REQ);
    end

    assign w_busy     = (r_state != S_IDLE);
    assign ps2_c_oe   = r_c_oe;
    assign ps2_d_oe   = r_d_oe;
    assign cpu.busy   = w_busy;
    assign cpu.done   = r_done;
    assign cpu.status = {28'b0, r_err_timeout, r_err_noack, r_d_oe, w_busy};

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_host_tx
// Brief    : Scoreboard bench with a behavioural PS/2 device model.
// Revision : 1.0
// ============================================================================
module tb_ps2_host_tx;

    localparam int INHIBIT_CYC = 20;
    localparam int REQ_CYC     = 4;
    localparam int TIMEOUT_CYC = 2000;
    localparam int PH          = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ps2_c_oe, ps2_d_oe;
    logic dev_c_low = 1'b0;
    logic dev_d_low = 1'b0;
    logic ps2_c_line, ps2_d_line;

    assign ps2_c_line = ~(ps2_c_oe | dev_c_low);
    assign ps2_d_line = ~(ps2_d_oe | dev_d_low);

    ps2_host_tx_if cpu ();

    ps2_host_tx #(
        .INHIBIT_CYC (INHIBIT_CYC),
        .REQ_CYC     (REQ_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_c    (ps2_c_line),
        .ps2_d    (ps2_d_line),
        .cpu      (cpu),
        .ps2_c_oe (ps2_c_oe),
        .ps2_d_oe (ps2_d_oe)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int exp_done = 0;
    logic [7:0] sb[$];

    always @(posedge clk) begin
        if (cpu.done === 1'b1) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input bit push);
        @(negedge clk);
        cpu.din = b;
        cpu.wr  = 1'b1;
        @(negedge clk);
        cpu.wr  = 1'b0;
        if (push) sb.push_back(b);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (cpu.busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", {31'b0, cpu.busy}, 32'd0);
        repeat (3) @(negedge clk);
    endtask

    // Device samples the data line at the end of each high phase, then clocks low
    task automatic dev_frame(input bit do_ack, output bit got_frame, output logic [10:0] bits);
        int t;
        got_frame = 1'b0;
        bits      = '0;
        t = 0;
        while (!(ps2_c_oe && ps2_d_oe) && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (t >= 400) return;
        t = 0;
        while (ps2_c_oe && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (t >= 400) return;
        got_frame = 1'b1;
        for (int k = 0; k < 11; k++) begin
            repeat (PH) @(negedge clk);
            bits[k] = ps2_d_line;
            if (k == 10 && do_ack) begin
                dev_d_low = 1'b1;
                repeat (4) @(negedge clk);
            end
            dev_c_low = 1'b1;
            repeat (PH) @(negedge clk);
            dev_c_low = 1'b0;
        end
        repeat (PH) @(negedge clk);
        dev_d_low = 1'b0;
    endtask

    task automatic score(input bit got, input logic [10:0] bits);
        logic [7:0] e;
        chk("frame_seen", {31'b0, got}, 32'd1);
        chk("sb_depth", sb.size(), 32'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        chk("start_bit", {31'b0, bits[0]}, 32'd0);
        chk("data_byte", {24'b0, bits[8:1]}, {24'b0, e});
        chk("parity_bit", {31'b0, bits[9]}, {31'b0, ~^e});
        chk("stop_bit", {31'b0, bits[10]}, 32'd1);
    endtask

    task automatic normal_xfer(input logic [7:0] b);
        bit got;
        logic [10:0] bits;
        fork
            dev_frame(1'b1, got, bits);
            send(b, 1'b1);
        join
        score(got, bits);
        wait_idle(500);
        exp_done++;
        chk("done_count", done_cnt, exp_done);
        chk("status_ok", cpu.status, 32'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit got;
        logic [10:0] bits;
        int n;

        cpu.wr  = 1'b0;
        cpu.din = 8'h00;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("rst_c_oe", {31'b0, ps2_c_oe}, 32'd0);
        chk("rst_d_oe", {31'b0, ps2_d_oe}, 32'd0);
        chk("rst_busy", {31'b0, cpu.busy}, 32'd0);
        chk("rst_done", {31'b0, cpu.done}, 32'd0);
        chk("rst_status", cpu.status, 32'd0);

        // 0xED with request timing measured
        fork
            dev_frame(1'b1, got, bits);
            begin
                send(8'hED, 1'b1);
                chk("busy_after_wr", {31'b0, cpu.busy}, 32'd1);
                n = 0;
                while (ps2_c_oe && !ps2_d_oe && n < 100) begin
                    n++;
                    @(negedge clk);
                end
                chk("inhibit_len", n, INHIBIT_CYC);
                n = 0;
                while (ps2_c_oe && ps2_d_oe && n < 100) begin
                    n++;
                    @(negedge clk);
                end
                chk("req_len", n, REQ_CYC);
            end
        join
        chk("ed_bits", {21'b0, bits}, {21'b0, 11'b11_1110_1101_0});
        score(got, bits);
        wait_idle(500);
        exp_done++;
        chk("ed_done", done_cnt, exp_done);
        chk("ed_status", cpu.status, 32'd0);

        normal_xfer(8'h00);
        normal_xfer(8'hFF);
        normal_xfer(8'h01);

        // No device answering
        send(8'hA5, 1'b0);
        n = 0;
        while (ps2_c_oe && n < 200) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (cpu.busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_len", n, TIMEOUT_CYC);
        chk("timeout_status", cpu.status, 32'h8);
        chk("timeout_oe", {30'b0, ps2_c_oe, ps2_d_oe}, 32'd0);
        repeat (3) @(negedge clk);
        chk("timeout_no_done", done_cnt, exp_done);

        // Device withholds the ACK
        fork
            dev_frame(1'b0, got, bits);
            send(8'h12, 1'b1);
        join
        score(got, bits);
        wait_idle(500);
        chk("noack_status", cpu.status, 32'h4);
        chk("noack_no_done", done_cnt, exp_done);

        fork
            dev_frame(1'b1, got, bits);
            begin
                send(8'h34, 1'b1);
                chk("noack_cleared", cpu.status & 32'h4, 32'd0);
            end
        join
        score(got, bits);
        wait_idle(500);
        exp_done++;
        chk("recover_done", done_cnt, exp_done);
        chk("recover_status", cpu.status, 32'd0);

        // Second wr in flight is dropped
        fork
            dev_frame(1'b1, got, bits);
            begin
                send(8'hF4, 1'b1);
                repeat (350) @(negedge clk);
                chk("drop_busy", {31'b0, cpu.busy}, 32'd1);
                send(8'h55, 1'b0);
            end
        join
        score(got, bits);
        wait_idle(500);
        exp_done++;
        chk("drop_done", done_cnt, exp_done);
        chk("drop_sb_empty", sb.size(), 32'd0);

        // Reset in the middle of the data bits
        fork
            dev_frame(1'b1, got, bits);
            begin
                send(8'h3C, 1'b0);
                repeat (420) @(negedge clk);
                chk("pre_rst_busy", {31'b0, cpu.busy}, 32'd1);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("rst_mid_oe", {30'b0, ps2_c_oe, ps2_d_oe}, 32'd0);
                chk("rst_mid_busy", {31'b0, cpu.busy}, 32'd0);
            end
        join
        repeat (10) @(negedge clk);
        chk("rst_mid_no_done", done_cnt, exp_done);
        normal_xfer(8'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
